// File: rtl/load_hazard_ctrl.sv
// load_hazard_ctrl: load-use hazard detector and pipeline-control FSM for the
// 5-stage pipeline. It drives the PC, IF/ID and ID/EX register controls.
// Load stalls last LOAD_STALL bubbles. A taken branch in EX flushes the pipe.
// mem_stall_req freezes the whole pipe.
// stall_count is a saturating count of load-use bubble cycles.
module load_hazard_ctrl #(
    parameter int REG_W      = 5,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] id_rs1,
    input  logic [REG_W-1:0] id_rs2,
    input  logic             id_use_rs1,
    input  logic             id_use_rs2,
    input  logic [REG_W-1:0] ex_rd,
    input  logic             ex_mem_read,
    input  logic             ex_branch_taken,
    input  logic             mem_stall_req,
    output logic             pc_write,
    output logic             ifid_write,
    output logic             ifid_flush,
    output logic             idex_bubble,
    output logic             stall_active,
    output logic [CNT_W-1:0] stall_count
);

    typedef enum logic {
        IDLE,
        LOAD_WAIT
    } state_t;

    // Remaining bubbles after the first one. A 3-bit field covers LOAD_STALL up to 7.
    localparam logic [2:0] STALL_INIT = 3'(LOAD_STALL - 1);

    state_t     state;
    state_t     state_next;
    logic [2:0] wait_cnt;
    logic [2:0] wait_cnt_next;
    logic       hz;

    // The ID instruction reads a register that the load in EX has not yet produced.
    // The use qualifiers stop unused source fields from causing stalls.
    assign hz = ex_mem_read && (ex_rd != '0) &&
                ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                 (id_use_rs2 && (id_rs2 == ex_rd)));

    // Prioritised control: reset, then freeze, then flush, then a new stall,
    // then a continuing stall.
    always_comb begin
        pc_write      = 1'b1;
        ifid_write    = 1'b1;
        ifid_flush    = 1'b0;
        idex_bubble   = 1'b0;
        stall_active  = 1'b0;
        state_next    = state;
        wait_cnt_next = wait_cnt;
        if (!rst) begin
            state_next    = IDLE;
            wait_cnt_next = 3'd0;
        end else if (mem_stall_req) begin
            pc_write   = 1'b0;
            ifid_write = 1'b0;
        end else if (ex_branch_taken) begin
            ifid_flush    = 1'b1;
            idex_bubble   = 1'b1;
            state_next    = IDLE;
            wait_cnt_next = 3'd0;
        end else if (state == IDLE && hz) begin
            pc_write     = 1'b0;
            ifid_write   = 1'b0;
            idex_bubble  = 1'b1;
            stall_active = 1'b1;
            if (LOAD_STALL > 1) begin
                state_next    = LOAD_WAIT;
                wait_cnt_next = STALL_INIT;
            end
        end else if (state == LOAD_WAIT) begin
            pc_write      = 1'b0;
            ifid_write    = 1'b0;
            idex_bubble   = 1'b1;
            stall_active  = 1'b1;
            wait_cnt_next = wait_cnt - 3'd1;
            if (wait_cnt == 3'd1) begin
                state_next = IDLE;
            end
        end
    end

    // State register and wait counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            wait_cnt <= 3'd0;
        end else begin
            state    <= state_next;
            wait_cnt <= wait_cnt_next;
        end
    end

    // Count load-use bubble cycles. The count stops at all-ones instead of wrapping.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            stall_count <= '0;
        end else if (stall_active && (stall_count != '1)) begin
            stall_count <= stall_count + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_load_hazard_ctrl.sv
// tb_load_hazard_ctrl: directed testbench for load_hazard_ctrl.
// It drives three instances from shared inputs:
//   d1 with LOAD_STALL=1,
//   d3 with LOAD_STALL=3,
//   d4 with LOAD_STALL=3 and CNT_W=4.
module tb_load_hazard_ctrl;

    // Control vector order: {pc_write, ifid_write, ifid_flush, idex_bubble, stall_active}
    localparam logic [4:0] DEF    = 5'b11000;
    localparam logic [4:0] STALL  = 5'b00011;
    localparam logic [4:0] FREEZE = 5'b00000;
    localparam logic [4:0] FLUSH  = 5'b11110;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] id_rs1, id_rs2, ex_rd;
    logic       id_use_rs1, id_use_rs2, ex_mem_read, ex_branch_taken, mem_stall_req;

    logic        d1_pc, d1_ifid, d1_flush, d1_bub, d1_sa;
    logic        d3_pc, d3_ifid, d3_flush, d3_bub, d3_sa;
    logic        d4_pc, d4_ifid, d4_flush, d4_bub, d4_sa;
    logic [31:0] d1_cnt, d3_cnt;
    logic [3:0]  d4_cnt;
    logic [4:0]  c1, c3, c4;

    int checks   = 0;
    int failures = 0;

    assign c1 = {d1_pc, d1_ifid, d1_flush, d1_bub, d1_sa};
    assign c3 = {d3_pc, d3_ifid, d3_flush, d3_bub, d3_sa};
    assign c4 = {d4_pc, d4_ifid, d4_flush, d4_bub, d4_sa};

    load_hazard_ctrl #(.REG_W(5), .LOAD_STALL(1), .CNT_W(32)) d1 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_stall_req(mem_stall_req), .pc_write(d1_pc), .ifid_write(d1_ifid),
        .ifid_flush(d1_flush), .idex_bubble(d1_bub), .stall_active(d1_sa),
        .stall_count(d1_cnt));

    load_hazard_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(32)) d3 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_stall_req(mem_stall_req), .pc_write(d3_pc), .ifid_write(d3_ifid),
        .ifid_flush(d3_flush), .idex_bubble(d3_bub), .stall_active(d3_sa),
        .stall_count(d3_cnt));

    load_hazard_ctrl #(.REG_W(5), .LOAD_STALL(3), .CNT_W(4)) d4 (
        .clk(clk), .rst(rst), .id_rs1(id_rs1), .id_rs2(id_rs2),
        .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .ex_rd(ex_rd),
        .ex_mem_read(ex_mem_read), .ex_branch_taken(ex_branch_taken),
        .mem_stall_req(mem_stall_req), .pc_write(d4_pc), .ifid_write(d4_ifid),
        .ifid_flush(d4_flush), .idex_bubble(d4_bub), .stall_active(d4_sa),
        .stall_count(d4_cnt));

    // Free-running clock.
    always #5 clk = ~clk;

    // Abort the run if it goes far beyond the expected length.
    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] timeout");
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs;
        id_rs1 = 5'd0; id_rs2 = 5'd0; ex_rd = 5'd0;
        id_use_rs1 = 1'b0; id_use_rs2 = 1'b0; ex_mem_read = 1'b0;
        ex_branch_taken = 1'b0; mem_stall_req = 1'b0;
    endtask

    task automatic load_hazard_rs1(input logic [4:0] r);
        ex_mem_read = 1'b1; ex_rd = r; id_rs1 = r; id_use_rs1 = 1'b1;
    endtask

    task automatic do_reset;
        clear_inputs();
        rst = 1'b0;
        #2;
        tick();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b0;
        load_hazard_rs1(5'd5);
        #3;
        checks++;
        if (c3 !== DEF) begin
            failures++;
            $display("[TB] FAIL reset_outputs: got %b expected %b", c3, DEF);
        end
        checks++;
        if (d3_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL reset_count: got %0d expected 0", d3_cnt);
        end
        tick();
        checks++;
        if (c1 !== DEF) begin
            failures++;
            $display("[TB] FAIL reset_hold_d1: got %b expected %b", c1, DEF);
        end
        clear_inputs();
        rst = 1'b1;
        #1;
    endtask

    task automatic test_single_stall;
        do_reset();
        load_hazard_rs1(5'd5);
        #1;
        checks++;
        if (c1 !== STALL) begin
            failures++;
            $display("[TB] FAIL single_stall: got %b expected %b", c1, STALL);
        end
        tick();
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if (c1 !== DEF) begin
            failures++;
            $display("[TB] FAIL single_after: got %b expected %b", c1, DEF);
        end
        checks++;
        if (d1_cnt !== 32'd1) begin
            failures++;
            $display("[TB] FAIL single_count: got %0d expected 1", d1_cnt);
        end
    endtask

    task automatic test_multi_stall;
        do_reset();
        ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < 3; i++) begin
                #1;
                checks++;
                if (c3 !== STALL) begin
                    failures++;
                    $display("[TB] FAIL multi_stall p%0d c%0d: got %b expected %b", pass, i, c3, STALL);
                end
                tick();
                clear_inputs();
            end
            #1;
            checks++;
            if (c3 !== DEF) begin
                failures++;
                $display("[TB] FAIL multi_end p%0d: got %b expected %b", pass, c3, DEF);
            end
            checks++;
            if (d3_cnt !== 32'(3 * (pass + 1))) begin
                failures++;
                $display("[TB] FAIL multi_count p%0d: got %0d expected %0d", pass, d3_cnt, 3 * (pass + 1));
            end
            ex_mem_read = 1'b1; ex_rd = 5'd7; id_rs2 = 5'd7; id_use_rs2 = 1'b1;
        end
        clear_inputs();
    endtask

    task automatic test_false_hazard;
        do_reset();
        for (int k = 0; k < 3; k++) begin
            clear_inputs();
            case (k)
                0: begin ex_mem_read = 1'b1; ex_rd = 5'd9; id_rs2 = 5'd9; id_use_rs2 = 1'b0; end
                1: begin ex_mem_read = 1'b1; ex_rd = 5'd0; id_rs1 = 5'd0; id_use_rs1 = 1'b1; end
                default: begin ex_mem_read = 1'b0; ex_rd = 5'd4; id_rs1 = 5'd4; id_use_rs1 = 1'b1; end
            endcase
            #1;
            checks++;
            if (c3 !== DEF) begin
                failures++;
                $display("[TB] FAIL false_hazard_%0d: got %b expected %b", k, c3, DEF);
            end
            tick();
        end
        clear_inputs();
        checks++;
        if (d3_cnt !== 32'd0) begin
            failures++;
            $display("[TB] FAIL false_count: got %0d expected 0", d3_cnt);
        end
    endtask

    task automatic test_freeze;
        logic [4:0] exp_seq [0:5];
        exp_seq[0] = STALL; exp_seq[1] = FREEZE; exp_seq[2] = FREEZE;
        exp_seq[3] = STALL; exp_seq[4] = STALL;  exp_seq[5] = DEF;
        do_reset();
        load_hazard_rs1(5'd3);
        for (int i = 0; i < 6; i++) begin
            mem_stall_req = (i == 1 || i == 2);
            #1;
            checks++;
            if (c3 !== exp_seq[i]) begin
                failures++;
                $display("[TB] FAIL freeze_c%0d: got %b expected %b", i, c3, exp_seq[i]);
            end
            tick();
            ex_mem_read = 1'b0;
        end
        clear_inputs();
        checks++;
        if (d3_cnt !== 32'd3) begin
            failures++;
            $display("[TB] FAIL freeze_count: got %0d expected 3", d3_cnt);
        end
    endtask

    task automatic test_branch_flush;
        do_reset();
        load_hazard_rs1(5'd6);
        tick();
        clear_inputs();
        ex_branch_taken = 1'b1;
        #1;
        checks++;
        if (c3 !== FLUSH) begin
            failures++;
            $display("[TB] FAIL flush_in_wait: got %b expected %b", c3, FLUSH);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (c3 !== DEF) begin
            failures++;
            $display("[TB] FAIL flush_to_idle: got %b expected %b", c3, DEF);
        end
        load_hazard_rs1(5'd6);
        tick();
        clear_inputs();
        ex_branch_taken = 1'b1;
        mem_stall_req = 1'b1;
        #1;
        checks++;
        if (c3 !== FREEZE) begin
            failures++;
            $display("[TB] FAIL flush_frozen: got %b expected %b", c3, FREEZE);
        end
        tick();
        mem_stall_req = 1'b0;
        #1;
        checks++;
        if (c3 !== FLUSH) begin
            failures++;
            $display("[TB] FAIL flush_after_freeze: got %b expected %b", c3, FLUSH);
        end
        tick();
        ex_branch_taken = 1'b0;
        #1;
        checks++;
        if (c3 !== DEF) begin
            failures++;
            $display("[TB] FAIL flush_idle2: got %b expected %b", c3, DEF);
        end
        checks++;
        if (d3_cnt !== 32'd2) begin
            failures++;
            $display("[TB] FAIL flush_count: got %0d expected 2", d3_cnt);
        end
    endtask

    task automatic test_saturate_and_reset;
        do_reset();
        load_hazard_rs1(5'd12);
        repeat (20) tick();
        checks++;
        if (d4_cnt !== 4'd15) begin
            failures++;
            $display("[TB] FAIL saturate: got %0d expected 15", d4_cnt);
        end
        checks++;
        if (d3_cnt !== 32'd20) begin
            failures++;
            $display("[TB] FAIL wide_count: got %0d expected 20", d3_cnt);
        end
        clear_inputs();
        repeat (3) tick();
        load_hazard_rs1(5'd12);
        tick();
        clear_inputs();
        #1;
        checks++;
        if (c4 !== STALL) begin
            failures++;
            $display("[TB] FAIL mid_wait: got %b expected %b", c4, STALL);
        end
        load_hazard_rs1(5'd12);
        rst = 1'b0;
        #1;
        checks++;
        if (c4 !== DEF) begin
            failures++;
            $display("[TB] FAIL async_reset_out: got %b expected %b", c4, DEF);
        end
        checks++;
        if (d4_cnt !== 4'd0) begin
            failures++;
            $display("[TB] FAIL async_reset_cnt: got %0d expected 0", d4_cnt);
        end
        clear_inputs();
        rst = 1'b1;
        #1;
        checks++;
        if (c4 !== DEF) begin
            failures++;
            $display("[TB] FAIL post_reset_idle: got %b expected %b", c4, DEF);
        end
    endtask

    // Run every scenario in sequence, then print the summary line.
    initial begin
        clear_inputs();
        rst = 1'b0;
        test_reset();
        test_single_stall();
        test_multi_stall();
        test_false_hazard();
        test_freeze();
        test_branch_flush();
        test_saturate_and_reset();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
